// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-sense constants and
// parameter legality checks used by the TX and RX blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam bit PARITY_SENSE_EVEN = 1'b0;
    localparam bit PARITY_SENSE_ODD  = 1'b1;

    // True when the frame geometry is one the TX/RX datapaths support.
    function automatic bit uart_cfg_ok(
        input int unsigned data_bits,
        input int unsigned oversample,
        input int unsigned stop_bits,
        input int unsigned parity_odd
    );
        return (data_bits >= 5) && (data_bits <= 9) &&
               (oversample >= 8) && ((oversample % 2) == 0) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (parity_odd <= 1);
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RST_VAL sets the
// value both stages take in reset (1 for an idle-high serial line).
module uart_sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with one-word valid/ready holding register.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (!uart_cfg_ok(DATA_BITS, OVERSAMPLE, STOP_BITS, PARITY_ODD)) begin : g_bad_cfg
        $error("uart_rx_param: unsupported DATA_BITS/OVERSAMPLE/STOP_BITS/PARITY_ODD");
    end

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 deliver_c;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 rx_sync;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            ferr_acc_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            ferr_acc_q   <= ferr_acc_d;
            perr_acc_q   <= perr_acc_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: counters only move on s_tick and restart on each state entry.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        perr_acc_d = perr_acc_q;
        deliver_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_tick && !rx_sync) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            bit_d      = '0;
                            ferr_acc_d = 1'b0;
                            perr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d    = ST_PARITY;
`else
                            state_d    = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        perr_acc_d = ((^shift_q) ^ rx_sync) != PARITY_ODD[0];
                        state_d    = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        ferr_acc_d = ferr_acc_q | ~rx_sync;
                        if (bit_q == STOP_LAST) begin
                            bit_d     = '0;
                            deliver_c = 1'b1;
                            state_d   = rx_sync ? ST_IDLE : ST_BREAK;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_BREAK: begin
                if (s_tick && rx_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: load when empty or being drained this clk, else overrun.
    always_comb begin
        dout_d       = dout_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        if (deliver_c) begin
            if (!valid_q || dout_ready) begin
                dout_d       = shift_q;
                valid_d      = 1'b1;
                frame_err_d  = ferr_acc_d;
                parity_err_d = perr_acc_d;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
